// File: rtl/eac_normalizer_pkg.sv
// Shared constants and select encoding for the end-around-carry normalizer.
// The pipeline and the bench both import this package.
package eac_normalizer_pkg;

  localparam int PARM_MANT = 23;
  localparam int W         = 2 * PARM_MANT + 2;
  localparam int PARM_LZC  = $clog2(W + 1);

  // Which adder output supplies the magnitude, and how sign/carry are derived.
  typedef enum logic [1:0] {
    SEL_ADD     = 2'd0,
    SEL_SUB_POS = 2'd1,
    SEL_SUB_NEG = 2'd2
  } sel_e;

  function automatic sel_e sel_decode(input logic sub_sign, input logic carry);
    if (!sub_sign) begin
      return SEL_ADD;
    end else if (carry) begin
      return SEL_SUB_POS;
    end else begin
      return SEL_SUB_NEG;
    end
  endfunction

endpackage

// File: rtl/eac_normalizer_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W and zero_o.
module eac_normalizer_lzc #(
  parameter int W  = 48,
  parameter int CW = 6
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) begin
        cnt_o = CW'(W - 1 - i);
      end
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/eac_normalizer.sv
// Two-stage normalizer: S1 selects the true or complemented adder result,
// S2 left-normalizes it. Valid/ready: a transfer happens when both are 1 at a rising edge.
module eac_normalizer #(
  parameter int PARM_MANT = eac_normalizer_pkg::PARM_MANT,
  parameter int PARM_LZC  = eac_normalizer_pkg::PARM_LZC,
  localparam int W        = 2 * PARM_MANT + 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [W-1:0]        low_sum_i,
  input  logic                low_carry_i,
  input  logic [W-1:0]        low_sum_inv_i,
  input  logic                low_carry_inv_i,
  input  logic                sub_sign_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [W-1:0]        mag_o,
  output logic [PARM_LZC-1:0] lz_cnt_o,
  output logic                carry_o,
  output logic                sign_inv_o,
  output logic                zero_o,
  output logic                dbg_carry_inv_o
);

  import eac_normalizer_pkg::*;

  logic                s1_valid_q, s1_valid_d;
  logic [W-1:0]        s1_mag_q, s1_mag_d;
  logic                s1_sign_inv_q, s1_sign_inv_d;
  logic                s1_carry_q, s1_carry_d;
  logic                s1_carry_inv_q, s1_carry_inv_d;

  logic                s2_valid_q, s2_valid_d;
  logic [W-1:0]        s2_mag_q, s2_mag_d;
  logic [PARM_LZC-1:0] s2_lz_q, s2_lz_d;
  logic                s2_carry_q, s2_carry_d;
  logic                s2_sign_inv_q, s2_sign_inv_d;
  logic                s2_zero_q, s2_zero_d;

  logic                s1_adv;
  logic                in_fire;
  logic [PARM_LZC-1:0] lz_cnt;
  logic                lz_zero;
  sel_e                sel;

  // ready_o depends only on stage state and ready_i, never on valid_i.
  assign s1_adv  = ~s2_valid_q | ready_i;
  assign ready_o = ~s1_valid_q | s1_adv;
  assign in_fire = valid_i & ready_o;
  assign sel     = sel_decode(sub_sign_i, low_carry_i);

  always_comb begin
    s1_valid_d     = s1_valid_q;
    s1_mag_d       = s1_mag_q;
    s1_sign_inv_d  = s1_sign_inv_q;
    s1_carry_d     = s1_carry_q;
    s1_carry_inv_d = s1_carry_inv_q;
    if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (in_fire) begin
      s1_valid_d     = 1'b1;
      s1_carry_inv_d = low_carry_inv_i;
      case (sel)
        SEL_SUB_POS: begin
          s1_mag_d      = low_sum_i;
          s1_sign_inv_d = 1'b0;
          s1_carry_d    = 1'b0;
        end
        SEL_SUB_NEG: begin
          s1_mag_d      = low_sum_inv_i;
          s1_sign_inv_d = 1'b1;
          s1_carry_d    = 1'b0;
        end
        default: begin
          s1_mag_d      = low_sum_i;
          s1_sign_inv_d = 1'b0;
          s1_carry_d    = low_carry_i;
        end
      endcase
    end
  end

  eac_normalizer_lzc #(
    .W  (W),
    .CW (PARM_LZC)
  ) u_lzc (
    .data_i (s1_mag_q),
    .cnt_o  (lz_cnt),
    .zero_o (lz_zero)
  );

  // S2 only reloads on a real S1 transfer, so held outputs stay stable.
  always_comb begin
    s2_valid_d    = s2_valid_q;
    s2_mag_d      = s2_mag_q;
    s2_lz_d       = s2_lz_q;
    s2_carry_d    = s2_carry_q;
    s2_sign_inv_d = s2_sign_inv_q;
    s2_zero_d     = s2_zero_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_adv && s1_valid_q) begin
      s2_mag_d      = s1_mag_q << lz_cnt;
      s2_lz_d       = lz_cnt;
      s2_carry_d    = s1_carry_q;
      s2_sign_inv_d = s1_sign_inv_q;
      s2_zero_d     = lz_zero;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q     <= 1'b0;
      s1_mag_q       <= '0;
      s1_sign_inv_q  <= 1'b0;
      s1_carry_q     <= 1'b0;
      s1_carry_inv_q <= 1'b0;
      s2_valid_q     <= 1'b0;
      s2_mag_q       <= '0;
      s2_lz_q        <= '0;
      s2_carry_q     <= 1'b0;
      s2_sign_inv_q  <= 1'b0;
      s2_zero_q      <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_mag_q       <= s1_mag_d;
      s1_sign_inv_q  <= s1_sign_inv_d;
      s1_carry_q     <= s1_carry_d;
      s1_carry_inv_q <= s1_carry_inv_d;
      s2_valid_q     <= s2_valid_d;
      s2_mag_q       <= s2_mag_d;
      s2_lz_q        <= s2_lz_d;
      s2_carry_q     <= s2_carry_d;
      s2_sign_inv_q  <= s2_sign_inv_d;
      s2_zero_q      <= s2_zero_d;
    end
  end

  assign valid_o         = s2_valid_q;
  assign mag_o           = s2_mag_q;
  assign lz_cnt_o        = s2_lz_q;
  assign carry_o         = s2_carry_q;
  assign sign_inv_o      = s2_sign_inv_q;
  assign zero_o          = s2_zero_q;
  assign dbg_carry_inv_o = s1_carry_inv_q;

endmodule

// File: tb/tb_eac_normalizer.sv
// Randomized and directed bench for eac_normalizer against a queue-based model
// of a two-deep in-order pipeline.
module tb_eac_normalizer;
  import eac_normalizer_pkg::*;

  localparam int LZ = PARM_LZC;
  localparam int EW = W + LZ + 3;

  logic          clk;
  logic          rst_n;
  logic          valid_i, ready_o, valid_o, ready_i;
  logic [W-1:0]  low_sum_i, low_sum_inv_i, mag_o;
  logic          low_carry_i, low_carry_inv_i, sub_sign_i;
  logic [LZ-1:0] lz_cnt_o;
  logic          carry_o, sign_inv_o, zero_o, dbg_carry_inv_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;
  int first_out_cyc = -1;
  bit acc_fire;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];

  eac_normalizer dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .low_sum_i       (low_sum_i),
    .low_carry_i     (low_carry_i),
    .low_sum_inv_i   (low_sum_inv_i),
    .low_carry_inv_i (low_carry_inv_i),
    .sub_sign_i      (sub_sign_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .mag_o           (mag_o),
    .lz_cnt_o        (lz_cnt_o),
    .carry_o         (carry_o),
    .sign_inv_o      (sign_inv_o),
    .zero_o          (zero_o),
    .dbg_carry_inv_o (dbg_carry_inv_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  // Expected result packed as {zero, sign_inv, carry, lz, mag}.
  function automatic logic [EW-1:0] model(input logic [W-1:0] sum, input logic carry,
                                          input logic [W-1:0] sum_inv, input logic sub);
    logic [W-1:0] m;
    int           lz;
    logic         si, co;
    m  = sub ? (carry ? sum : sum_inv) : sum;
    si = sub && !carry;
    co = !sub && carry;
    lz = 0;
    if (m == '0) begin
      lz = W;
    end else begin
      while (!m[W-1]) begin
        m  = m << 1;
        lz = lz + 1;
      end
    end
    return {(lz == W), si, co, LZ'(lz), m};
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [63:0] r;
    int          k;
    r = {$urandom(), $urandom()};
    k = $urandom_range(0, 9);
    if (k == 0) return '0;
    if (k < 5) return W'(r) >> $urandom_range(1, W - 1);
    return W'(r);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: runs once per cycle with inputs settled, before the rising edge
  task automatic check();
    logic [EW-1:0] e;
    bit            exp_valid;
    exp_valid = (exp_q.size() > 0) && (acc_q[0] <= cyc - 2);
    chk("ready_o", ready_o, (exp_q.size() < 2) || ready_i);
    chk("valid_o", valid_o, exp_valid);
    if (valid_o && exp_valid) begin
      e = exp_q[0];
      chk("mag_o", mag_o, e[W-1:0]);
      chk("lz_cnt_o", lz_cnt_o, e[W+LZ-1:W]);
      chk("carry_o", carry_o, e[W+LZ]);
      chk("sign_inv_o", sign_inv_o, e[W+LZ+1]);
      chk("zero_o", zero_o, e[W+LZ+2]);
    end
    if (valid_o && ready_i && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
      n_out++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end
    acc_fire = valid_i && ready_o;
    if (acc_fire) begin
      exp_q.push_back(model(low_sum_i, low_carry_i, low_sum_inv_i, sub_sign_i));
      acc_q.push_back(cyc);
      n_acc++;
    end
    cyc++;
  endtask

  // driver tasks
  task automatic apply(input bit v, input logic [W-1:0] s, input bit c,
                       input logic [W-1:0] si, input bit ci, input bit sub, input bit rdy);
    valid_i         = v;
    low_sum_i       = s;
    low_carry_i     = c;
    low_sum_inv_i   = si;
    low_carry_inv_i = ci;
    sub_sign_i      = sub;
    ready_i         = rdy;
    #1;
    check();
    @(negedge clk);
  endtask

  task automatic rand_apply(input bit v, input bit rdy);
    apply(v, rnd_w(), 1'($urandom_range(0, 1)), rnd_w(), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) rand_apply(1'b0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic directed(input string name, input logic [W-1:0] s, input bit c,
                          input logic [W-1:0] si, input bit sub, input logic [W-1:0] e_mag,
                          input int e_lz, input bit e_c, input bit e_si, input bit e_z);
    drain();
    apply(1'b1, s, c, si, 1'b0, sub, 1'b1);
    rand_apply(1'b0, 1'b1);
    chk({name, "_valid"}, valid_o, 1);
    chk({name, "_mag"}, mag_o, e_mag);
    chk({name, "_lz"}, lz_cnt_o, e_lz);
    chk({name, "_carry"}, carry_o, e_c);
    chk({name, "_sign_inv"}, sign_inv_o, e_si);
    chk({name, "_zero"}, zero_o, e_z);
  endtask

  logic [W-1:0] bp_sum[3];
  logic [W-1:0] bp_inv[3];
  bit           bp_c[3];
  bit           bp_sub[3];

  initial begin
    int idx, acc0, out0, start;
    rst_n = 1'b0;
    valid_i = 1'b0; ready_i = 1'b0; low_sum_i = '0; low_sum_inv_i = '0;
    low_carry_i = 1'b0; low_carry_inv_i = 1'b0; sub_sign_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_ready_o", ready_o, 1);
    chk("rst_mag_o", mag_o, 0);
    chk("rst_lz_cnt_o", lz_cnt_o, 0);
    chk("rst_flags", {carry_o, sign_inv_o, zero_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    directed("add_carry", 48'h0000_0000_0001, 1'b1, 48'hFFFF_FFFF_FFFE, 1'b0,
             48'h8000_0000_0000, 47, 1'b1, 1'b0, 1'b0);
    directed("sub_neg", 48'h1234_5678_9ABC, 1'b0, 48'h0F00_0000_0000, 1'b1,
             48'hF000_0000_0000, 4, 1'b0, 1'b1, 1'b0);
    directed("sub_zero", 48'h0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1,
             48'h0, 48, 1'b0, 1'b0, 1'b1);
    directed("add_zero_nc", 48'h0, 1'b0, 48'h0000_0000_00FF, 1'b0,
             48'h0, 48, 1'b0, 1'b0, 1'b1);
    directed("sub_msb_set", 48'h0, 1'b0, 48'h8000_0000_0001, 1'b1,
             48'h8000_0000_0001, 0, 1'b0, 1'b1, 1'b0);

    // backpressure: three back-to-back inputs against a stalled output
    drain();
    for (int i = 0; i < 3; i++) begin
      bp_sum[i] = rnd_w(); bp_inv[i] = rnd_w();
      bp_c[i] = 1'($urandom_range(0, 1)); bp_sub[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; acc0 = n_acc; out0 = n_out;
    for (int k = 0; k < 4; k++) begin
      apply(idx < 3, bp_sum[idx % 3], bp_c[idx % 3], bp_inv[idx % 3], 1'b0, bp_sub[idx % 3], 1'b0);
      if (acc_fire) idx++;
    end
    #1;
    chk("bp_accepted", n_acc - acc0, 2);
    chk("bp_ready_low", ready_o, 0);
    for (int k = 0; k < 10 && idx < 3; k++) begin
      apply(1'b1, bp_sum[idx], bp_c[idx], bp_inv[idx], 1'b0, bp_sub[idx], 1'b1);
      if (acc_fire) idx++;
    end
    drain();
    chk("bp_delivered", n_out - out0, 3);

    // throughput: ten consecutive inputs with ready_i held high
    drain();
    first_out_cyc = -1; out0 = n_out; start = cyc;
    for (int k = 0; k < 10; k++) rand_apply(1'b1, 1'b1);
    rand_apply(1'b0, 1'b1);
    rand_apply(1'b0, 1'b1);
    chk("tp_first_latency", first_out_cyc - start, 2);
    chk("tp_count", n_out - out0, 10);

    // reset with both stages full
    drain();
    rand_apply(1'b1, 1'b0);
    rand_apply(1'b1, 1'b0);
    #1;
    chk("full_ready_low", ready_o, 0);
    chk("full_valid", valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_o", valid_o, 0);
    chk("mid_rst_ready_o", ready_o, 1);
    chk("mid_rst_mag_o", mag_o, 0);
    chk("mid_rst_lz_cnt_o", lz_cnt_o, 0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out0 = n_out;
    rand_apply(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) rand_apply(1'b0, 1'b1);
    chk("post_rst_single", n_out - out0, 1);

    // random traffic with random backpressure
    for (int k = 0; k < 600; k++) begin
      rand_apply($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
